// File: rtl/hazard_ctrl_if.sv
// Handshake bundle between the pipeline datapath and hazard_ctrl.
// Carries ID/EX hazard inputs, pipeline-register controls and statistics.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       IF_IDrs;
    logic [4:0]       IF_IDrt;
    logic             IF_ID_uses_rt;
    logic [4:0]       ID_EXrt;
    logic             MemRead_ID_EX;
    logic             branch_taken_EX;
    logic             mem_busy;
    logic             pc_write;
    logic             IF_ID_write;
    logic             IF_ID_flush;
    logic             ID_EX_hold;
    logic             ID_EX_bubble;
    logic             EX_MEM_hold;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;
    logic             mem_timeout;

    modport master (
        output IF_IDrs, IF_IDrt, IF_ID_uses_rt, ID_EXrt,
        output MemRead_ID_EX, branch_taken_EX, mem_busy,
        input  pc_write, IF_ID_write, IF_ID_flush,
        input  ID_EX_hold, ID_EX_bubble, EX_MEM_hold,
        input  stall_count, flush_count, mem_timeout
    );

    modport slave (
        input  IF_IDrs, IF_IDrt, IF_ID_uses_rt, ID_EXrt,
        input  MemRead_ID_EX, branch_taken_EX, mem_busy,
        output pc_write, IF_ID_write, IF_ID_flush,
        output ID_EX_hold, ID_EX_bubble, EX_MEM_hold,
        output stall_count, flush_count, mem_timeout
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: load-use stalls, branch flushes, memory freezes.
// Tracks saturating stall/flush statistics and a sticky memory timeout.
module hazard_ctrl #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 16
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hz
);
    localparam int WW = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MEM_WAIT_MAX);

    typedef enum logic {
        RUN,
        MEM_WAIT
    } state_e;

    state_e           state_q, state_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic             tmo_q, tmo_d;

    logic lu_hazard;
    logic rt_match;
    logic rs_match;
    logic do_freeze;
    logic do_flush;
    logic do_stall;

    logic pc_write_c;
    logic if_id_write_c;
    logic if_id_flush_c;
    logic id_ex_hold_c;
    logic id_ex_bubble_c;
    logic ex_mem_hold_c;

    // Writes to $0 are discarded, so a load into $0 never creates a dependency.
    always_comb begin
        rs_match  = (hz.ID_EXrt == hz.IF_IDrs);
        rt_match  = hz.IF_ID_uses_rt && (hz.ID_EXrt == hz.IF_IDrt);
        lu_hazard = hz.MemRead_ID_EX && (hz.ID_EXrt != 5'd0)
                    && (rs_match || rt_match);
    end

    always_comb begin
        do_freeze = !rst && hz.mem_busy;
        do_flush  = !rst && !hz.mem_busy && hz.branch_taken_EX;
        do_stall  = !rst && !hz.mem_busy && !hz.branch_taken_EX
                    && lu_hazard;
    end

    always_comb begin
        pc_write_c     = 1'b1;
        if_id_write_c  = 1'b1;
        if_id_flush_c  = 1'b0;
        id_ex_hold_c   = 1'b0;
        id_ex_bubble_c = 1'b0;
        ex_mem_hold_c  = 1'b0;
        if (rst) begin
            pc_write_c     = 1'b0;
            if_id_write_c  = 1'b0;
            id_ex_bubble_c = 1'b1;
        end else if (do_freeze) begin
            pc_write_c    = 1'b0;
            if_id_write_c = 1'b0;
            id_ex_hold_c  = 1'b1;
            ex_mem_hold_c = 1'b1;
        end else if (do_flush) begin
            if_id_flush_c  = 1'b1;
            id_ex_bubble_c = 1'b1;
        end else if (do_stall) begin
            pc_write_c     = 1'b0;
            if_id_write_c  = 1'b0;
            id_ex_bubble_c = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            RUN: begin
                if (hz.mem_busy) begin
                    state_d = MEM_WAIT;
                    wait_d  = WW'(1);
                end
            end
            MEM_WAIT: begin
                if (hz.mem_busy) begin
                    if (wait_q != WAIT_MAX) begin
                        wait_d = wait_q + WW'(1);
                    end
                end else begin
                    state_d = RUN;
                    wait_d  = '0;
                end
            end
            default: begin
                state_d = RUN;
                wait_d  = '0;
            end
        endcase
        // Sticky: the freeze itself keeps going, only rst clears the flag.
        if (hz.mem_busy && (wait_q == WAIT_MAX)) begin
            tmo_d = 1'b1;
        end
    end

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (!pc_write_c && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
        if (do_flush && (flush_q != '1)) begin
            flush_d = flush_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            wait_q  <= '0;
            stall_q <= '0;
            flush_q <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
            tmo_q   <= tmo_d;
        end
    end

    assign hz.pc_write     = pc_write_c;
    assign hz.IF_ID_write  = if_id_write_c;
    assign hz.IF_ID_flush  = if_id_flush_c;
    assign hz.ID_EX_hold   = id_ex_hold_c;
    assign hz.ID_EX_bubble = id_ex_bubble_c;
    assign hz.EX_MEM_hold  = ex_mem_hold_c;
    assign hz.stall_count  = stall_q;
    assign hz.flush_count  = flush_q;
    assign hz.mem_timeout  = tmo_q;
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline control unit that drives the capture side of the IF/ID and ID/EX pipeline registers. It decides each cycle whether those registers load, hold, or take a bubble, and whether PC advances.
- Inputs: decoded register fields and control bits from ID and EX, branch resolution from EX, and a data-memory busy signal.
- Handles load-use stalls, taken-branch flushes and multi-cycle memory freezes.
- Keeps stall and flush statistics and a sticky memory-timeout flag.

Parameters:
MEM_WAIT_MAX, 15, consecutive mem_busy cycles after which mem_timeout is raised (≥1)
CNT_W, 16, width of the saturating statistics counters

Ports:
clk  input  1  pipeline clock; all state updates on posedge
rst  input  1  asynchronous, active-high reset
IF_IDrs  input  5  rs field of the instruction in ID
IF_IDrt  input  5  rt field of the instruction in ID
IF_ID_uses_rt  input  1  ID instruction reads rt as a source (R-type, store, branch)
ID_EXrt  input  5  rt (load destination) of the instruction in EX
MemRead_ID_EX  input  1  instruction in EX is a load
branch_taken_EX  input  1  branch/jump in EX resolved taken this cycle
mem_busy  input  1  data memory cannot complete the MEM-stage access this cycle
pc_write  output  1  PC loads next value
IF_ID_write  output  1  IF/ID register loads
IF_ID_flush  output  1  IF/ID loads a NOP
ID_EX_hold  output  1  ID/EX register keeps its contents
ID_EX_bubble  output  1  ID/EX loads all-zero control signals
EX_MEM_hold  output  1  EX/MEM and MEM/WB keep their contents
stall_count  output  CNT_W  cycles with pc_write=0 (saturating)
flush_count  output  CNT_W  taken-branch flushes (saturating)
mem_timeout  output  1  sticky, memory wait exceeded MEM_WAIT_MAX

Behaviour:
- Reset (rst=1, async):
  - state=RUN, wait_cnt=0, stall_count=0, flush_count=0, mem_timeout=0.
  - While rst is high: pc_write=0, IF_ID_write=0, IF_ID_flush=0, ID_EX_hold=0, ID_EX_bubble=1, EX_MEM_hold=0.
- Control outputs are combinational from the current inputs. State and counters are registered.
- Definitions:
  - lu_hazard = MemRead_ID_EX & (ID_EXrt!=0) & ((ID_EXrt==IF_IDrs) | (IF_ID_uses_rt & (ID_EXrt==IF_IDrt)))
- Priority, highest first:
  - 1. mem_busy=1 (freeze): pc_write=0, IF_ID_write=0, IF_ID_flush=0, ID_EX_hold=1, ID_EX_bubble=0, EX_MEM_hold=1. A simultaneous branch_taken_EX or lu_hazard is ignored this cycle; both re-evaluate after the freeze because ID/EX is held.
  - 2. branch_taken_EX=1: pc_write=1, IF_ID_write=1, IF_ID_flush=1, ID_EX_bubble=1, holds 0. This overrides lu_hazard, since the dependent instruction is squashed anyway.
  - 3. lu_hazard=1: pc_write=0, IF_ID_write=0, ID_EX_bubble=1, flush/holds 0. Exactly one bubble is inserted; next cycle MemRead_ID_EX=0, so the hazard clears.
  - 4. Otherwise: pc_write=1, IF_ID_write=1, all other control outputs 0.
- State machine {RUN, MEM_WAIT}:
  - RUN -> MEM_WAIT when mem_busy=1 at a posedge; wait_cnt<=1.
  - MEM_WAIT with mem_busy=1: stay; wait_cnt increments, saturating at MEM_WAIT_MAX.
  - MEM_WAIT -> RUN when mem_busy=0 at a posedge; wait_cnt<=0.
  - mem_timeout<=1 at the posedge where wait_cnt==MEM_WAIT_MAX and mem_busy=1 (the MEM_WAIT_MAX+1-th consecutive busy cycle).
  - mem_timeout is cleared only by rst. The freeze continues regardless of timeout.
- Counters:
  - stall_count increments at each posedge where pc_write=0 (freeze or load-use).
  - flush_count increments at each posedge where rule 2 is active.
  - Both saturate at 2^CNT_W-1 with no wrap.
- Register $0 never causes a load-use stall.
- Reset asserted mid-freeze or mid-stall takes effect immediately. After release, operation resumes in RUN with wait_cnt=0.

Test Plan:
- Load-use: MemRead_ID_EX=1, ID_EXrt=8, IF_IDrs=8 for one cycle -> pc_write=0, IF_ID_write=0, ID_EX_bubble=1 for that cycle only; stall_count 0->1.
- $0 and rt-unused cases: ID_EXrt=0 matching IF_IDrs=0 -> no stall. ID_EXrt=9, IF_IDrt=9, IF_ID_uses_rt=0 -> no stall.
- Branch vs load-use: branch_taken_EX=1 with lu_hazard=1 -> IF_ID_flush=1, ID_EX_bubble=1, pc_write=1; flush_count=1; stall_count unchanged.
- Freeze: mem_busy high for 3 cycles with branch_taken_EX=1 -> ID_EX_hold=EX_MEM_hold=1 and pc_write=0 for 3 cycles; branch flush occurs on the 4th cycle; stall_count=3; mem_timeout stays 0.
- Timeout (MEM_WAIT_MAX=4): mem_busy high for 5 cycles -> mem_timeout=1 after the 5th edge. It stays 1 after mem_busy drops; rst clears it.
- Reset mid-freeze: rst pulsed while mem_busy=1 in MEM_WAIT -> outputs immediately at reset values, counters 0. After release with mem_busy=0 -> pc_write=1 in RUN.
